// File: rtl/multicycle_controller_if.sv
// Control bundle between the multi-cycle controller and the datapath/memory.
// master = controller side, slave = datapath side.
interface multicycle_controller_if #(
  parameter int CNT_W = 16
);
  // mem_ready: asserted by memory in the cycle the current access completes.
  // The controller holds address/strobes stable until it sees it high, and
  // only looks at it in FETCH, MEMREAD and MEMWRITE.
  logic [6:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             pc_write;
  logic             adr_src;
  logic             mem_write;
  logic             ir_write;
  logic [1:0]       result_src;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic             reg_write;
  logic             illegal;
  logic [3:0]       state;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, adr_src, mem_write, ir_write, result_src,
           alu_src_a, alu_src_b, alu_op, reg_write, illegal, state, instr_count
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, adr_src, mem_write, ir_write, result_src,
           alu_src_a, alu_src_b, alu_op, reg_write, illegal, state, instr_count
  );
endinterface

// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle RV32 core: Moore-decoded datapath
// controls, memory-ready stalls, sticky illegal flag and a retire counter.
module multicycle_controller #(
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_BEQ      = 4'd8,
    S_JAL      = 4'd9,
    S_ERROR    = 4'd10
  } state_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             illegal_q, illegal_d;
  logic             retire;

  logic       pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      count_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_ERROR;
        endcase
      end
      // The IR is not reloaded until the next FETCH, so opcode still tells lw from sw.
      S_MEMADR:   state_d = (bus.opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (bus.mem_ready) state_d = S_MEMWB;
      S_MEMWB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_MEMWRITE: begin
        if (bus.mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXECR:    state_d = S_ALUWB;
      S_ALUWB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_BEQ: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_JAL:      state_d = S_ALUWB;
      S_ERROR:    state_d = S_ERROR;
      default:    state_d = S_FETCH;
    endcase
    count_d   = count_q + CNT_W'(retire);
    illegal_d = illegal_q | (state_d == S_ERROR);
  end

  // Moore control decode; everything is held low while reset is asserted.
  always_comb begin
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          alu_src_b  = 2'b10;
          result_src = 2'b10;
          ir_write   = bus.mem_ready;
          pc_write   = bus.mem_ready;
        end
        S_DECODE: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
        end
        S_MEMADR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
        end
        S_MEMREAD:  adr_src = 1'b1;
        S_MEMWB: begin
          result_src = 2'b01;
          reg_write  = 1'b1;
        end
        S_MEMWRITE: begin
          adr_src   = 1'b1;
          mem_write = 1'b1;
        end
        S_EXECR: begin
          alu_src_a = 2'b10;
          alu_op    = 2'b10;
        end
        S_ALUWB:    reg_write = 1'b1;
        S_BEQ: begin
          alu_src_a = 2'b10;
          alu_op    = 2'b01;
          pc_write  = bus.zero;
        end
        S_JAL: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          pc_write  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.pc_write    = pc_write;
  assign bus.adr_src     = adr_src;
  assign bus.mem_write   = mem_write;
  assign bus.ir_write    = ir_write;
  assign bus.result_src  = result_src;
  assign bus.alu_src_a   = alu_src_a;
  assign bus.alu_src_b   = alu_src_b;
  assign bus.alu_op      = alu_op;
  assign bus.reg_write   = reg_write;
  assign bus.illegal     = illegal_q & ~rst;
  assign bus.state       = state_q;
  assign bus.instr_count = count_q;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Main control FSM for the multi-cycle RV32 core. It sequences fetch, decode, execute, memory and writeback over the shared ALU, unified memory and register file. It drives the 2-bit ALUOp into the existing ALU-control decoder, which resolves funct3/funct7. It also stalls on a memory-ready handshake and counts retired instructions.

Parameters:
CNT_W, 16, width of retired-instruction counter (wraps modulo 2^CNT_W)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
opcode  input  7  instr[6:0] from instruction register
zero  input  1  ALU zero flag
mem_ready  input  1  memory completes current access this cycle
pc_write  output  1  PC load enable
adr_src  output  1  memory address select (0 = PC, 1 = ALU result reg)
mem_write  output  1  memory write strobe
ir_write  output  1  instruction/old-PC register load
result_src  output  2  00 ALUOut reg, 01 mem data, 10 ALU result
alu_src_a  output  2  00 PC, 01 old PC, 10 rs1 reg
alu_src_b  output  2  00 rs2 reg, 01 immediate, 10 constant 4
alu_op  output  2  to ALU control: 00 add, 01 sub, 10 funct-decoded
reg_write  output  1  register-file write enable
illegal  output  1  sticky unsupported-opcode flag
state  output  4  current state encoding (debug/verification)
instr_count  output  CNT_W  retired-instruction count

Behaviour:
- State encoding fixed: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, ALUWB 7, BEQ 8, JAL 9, ERROR 10.
- Reset: on any clk edge with rst=1, state<=FETCH, instr_count<=0, illegal<=0. This applies from every state, including mid-access. While rst=1, all control outputs are forced to 0.
- Outputs are Moore, decoded from state. Any output not listed for a state is 0.
- FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10. ir_write=pc_write=mem_ready. Stays in FETCH until mem_ready=1, then goes to DECODE.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (branch target).
  - Next state by opcode: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECR; 1100011 -> BEQ; 1101111 -> JAL; any other -> ERROR.
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Goes to MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: adr_src=1. Holds until mem_ready=1, then goes to MEMWB.
- MEMWB: result_src=01, reg_write=1. Goes to FETCH (retire).
- MEMWRITE: adr_src=1, mem_write=1, held every cycle until mem_ready=1. Then goes to FETCH (retire). mem_write deasserts in the cycle after the ready cycle.
- EXECR: alu_src_a=10, alu_src_b=00, alu_op=10. Goes to ALUWB.
- ALUWB: result_src=00, reg_write=1. Goes to FETCH (retire).
- BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, pc_write=zero. Goes to FETCH (retire).
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1. Goes to ALUWB.
- ERROR: all strobes 0, illegal=1. Stays in ERROR until rst. instr_count is not incremented.
- Retire: instr_count increments by 1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ. It wraps from all-ones to 0.
- Instruction latencies with mem_ready held high: lw 5, sw 4, R-type 4, beq 3, jal 4 cycles. Each wait cycle with mem_ready=0 adds one cycle.
- mem_ready is ignored in all non-memory states.

Test Plan:
- rst=1 for 2 cycles, then release with mem_ready=1 and opcode=0110011 -> states 0,1,6,7,0; alu_op=10 only in state 6; reg_write=1 only in state 7; instr_count=1.
- lw (0000011) with mem_ready low for 3 cycles in MEMREAD -> adr_src=1 held 4 cycles; state 4 asserts result_src=01, reg_write=1; total 8 cycles; count +1.
- sw (0100011) with mem_ready=1 -> mem_write=1 for exactly 1 cycle in state 5; reg_write never 1; next state 0.
- beq with zero=1, then beq with zero=0 -> pc_write=1 in state 8 for the first and 0 for the second; both increment the count.
- opcode 0010111 in DECODE -> state 10, illegal=1 held 20 cycles, count frozen; rst -> illegal=0, state 0.
- CNT_W=4: retire 17 R-type instructions -> instr_count=1. Assert rst while in MEMREAD -> next state 0, all outputs 0 during the rst cycle.
